ysyx_23060229_lsu: RTL

Load/store unit: the responder end of the decoder's memory-control outputs (mem_ren, mem_wen, mem_wmask plus load width). It accepts one memory operation per handshake from the execute stage and drives a single-outstanding request/response memory bus. Store data and strobes are lane-aligned; load data is lane-extracted and sign- or zero-extended. It returns a writeback response to the writeback stage.

---
 rtl/ysyx_23060229_lsu.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060229_lsu.sv
// Load/store unit: accepts one memory operation at a time from execute,
// runs it on a single-outstanding request/response bus, and returns a
// lane-extracted, extended load result (or error) to writeback.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a new operation
// S_REQ  | memory request presented, waiting for m_req_ready
// S_WAIT | request accepted, waiting for the m_rsp_valid pulse
// S_RESP | result presented, waiting for rsp_ready
module ysyx_23060229_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                mem_ren,
  input  logic                mem_wen,
  input  logic [7:0]          mem_wmask,
  input  logic [2:0]          ld_funct3,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_rsp_valid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  m_req_valid_q, m_req_valid_d;
  logic                  m_we_q, m_we_d;
  logic [ADDR_W-1:0]     m_addr_q, m_addr_d;
  logic [DATA_W-1:0]     m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0]   m_wstrb_q, m_wstrb_d;
  logic [1:0]            lane_q, lane_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  load_q, load_d;

  logic                  is_load, is_store, bad_op, misaligned;
  logic [DATA_W/8-1:0]   strb_base;
  logic [DATA_W-1:0]     shifted, ld_val;

  // Classify the offered operation; a load wins when both enables are set.
  always_comb begin
    is_load    = mem_ren;
    is_store   = mem_wen & ~mem_ren;
    bad_op     = 1'b0;
    misaligned = 1'b0;
    strb_base  = '0;
    if (is_load) begin
      case (ld_funct3)
        3'b000, 3'b100: misaligned = 1'b0;
        3'b001, 3'b101: misaligned = addr[0];
        3'b010:         misaligned = |addr[1:0];
        default:        bad_op = 1'b1;
      endcase
    end else if (is_store) begin
      case (mem_wmask)
        8'h01: strb_base = 4'b0001;
        8'h03: begin strb_base = 4'b0011; misaligned = addr[0];     end
        8'h0F: begin strb_base = 4'b1111; misaligned = |addr[1:0];  end
        default: bad_op = 1'b1;
      endcase
    end
  end

  // Pull the addressed lane down to bit 0 and extend it by load width.
  always_comb begin
    shifted = m_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_val = {24'b0, shifted[7:0]};
      3'b101:  ld_val = {16'b0, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

  // Next-state and next-output logic for the operation sequencer.
  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = rsp_valid_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    m_req_valid_d = m_req_valid_q;
    m_we_d        = m_we_q;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    m_wstrb_d     = m_wstrb_q;
    lane_d        = lane_q;
    funct3_d      = funct3_q;
    load_d        = load_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          lane_d   = addr[1:0];
          funct3_d = ld_funct3;
          load_d   = is_load;
          if (bad_op || misaligned) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = '0;
          end else if (!is_load && !is_store) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b0;
            rdata_d     = '0;
          end else begin
            state_d       = S_REQ;
            m_req_valid_d = 1'b1;
            m_we_d        = is_store;
            m_addr_d      = {addr[ADDR_W-1:2], 2'b00};
            m_wdata_d     = is_store ? (wdata << {addr[1:0], 3'b000}) : '0;
            m_wstrb_d     = strb_base << addr[1:0];
          end
        end
      end
      S_REQ: begin
        if (m_req_ready) begin
          state_d       = S_WAIT;
          m_req_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (m_rsp_valid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          err_d       = m_rsp_err;
          rdata_d     = (m_rsp_err || !load_q) ? '0 : ld_val;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs; reset clears everything including req_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      m_req_valid_q <= 1'b0;
      m_we_q        <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      m_wstrb_q     <= '0;
      lane_q        <= '0;
      funct3_q      <= '0;
      load_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      m_req_valid_q <= m_req_valid_d;
      m_we_q        <= m_we_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      m_wstrb_q     <= m_wstrb_d;
      lane_q        <= lane_d;
      funct3_q      <= funct3_d;
      load_q        <= load_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign m_req_valid = m_req_valid_q;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_wstrb     = m_wstrb_q;

endmodule
